// File: rtl/demux6out_if.sv
// Bus bundle for the six-way result demultiplexer: producer offer, six channel
// outputs with valid/ready, and the order-error status (ErrCnt with DEMUX6_ERRCNT_EN).
interface demux6out_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 6
);
  // Handshake rule for both sides: a word moves on a rising edge where its
  // valid and ready are both 1; the offering side holds data and valid
  // stable until then, and ready never looks at valid.
  logic [2:0]       Order;
  logic [WIDTH-1:0] DataIn;
  logic             ValidIn;
  logic             ReadyIn;
  logic [WIDTH-1:0] DataOut0;
  logic [WIDTH-1:0] DataOut1;
  logic [WIDTH-1:0] DataOut2;
  logic [WIDTH-1:0] DataOut3;
  logic [WIDTH-1:0] DataOut4;
  logic [WIDTH-1:0] DataOut5;
  logic [NCH-1:0]   ValidOut;
  logic [NCH-1:0]   ReadyOut;
  logic             ErrClr;
  logic             OrderErr;
`ifdef DEMUX6_ERRCNT_EN
  logic [7:0]       ErrCnt;

  modport master (
    output Order, DataIn, ValidIn, ReadyOut, ErrClr,
    input  ReadyIn, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4, DataOut5,
    input  ValidOut, OrderErr, ErrCnt
  );

  modport slave (
    input  Order, DataIn, ValidIn, ReadyOut, ErrClr,
    output ReadyIn, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4, DataOut5,
    output ValidOut, OrderErr, ErrCnt
  );
`else
  modport master (
    output Order, DataIn, ValidIn, ReadyOut, ErrClr,
    input  ReadyIn, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4, DataOut5,
    input  ValidOut, OrderErr
  );

  modport slave (
    input  Order, DataIn, ValidIn, ReadyOut, ErrClr,
    output ReadyIn, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4, DataOut5,
    output ValidOut, OrderErr
  );
`endif
endinterface

// File: rtl/demux6out.sv
// Six-way demultiplexer with a single-entry holding register per channel.
// Optional dropped-word counter ErrCnt is built when DEMUX6_ERRCNT_EN is defined.
module demux6out #(
  parameter int WIDTH = 32,
  parameter int NCH   = 6
) (
  input logic        clk,
  input logic        rst,
  demux6out_if.slave bus
);

  logic [WIDTH-1:0] data_q [NCH];
  logic [NCH-1:0]   valid_q;
  logic [NCH-1:0]   valid_d;
  logic [NCH-1:0]   sel;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   drain;
  logic             order_ok;
  logic             ready_in;
  logic             xfer;
  logic             err_set;
  logic             order_err_q;

  // One-hot decode; codes 6 and 7 match no channel, so sel stays zero.
  always_comb begin
    sel = '0;
    for (int n = 0; n < NCH; n++) begin
      sel[n] = (bus.Order == 3'(n));
    end
  end

  assign order_ok = |sel;

  // Masked reduction rather than indexing by Order keeps invalid codes in range.
  assign ready_in = order_ok ? |(sel & (~valid_q | bus.ReadyOut)) : 1'b1;
  assign xfer     = bus.ValidIn & ready_in;
  assign err_set  = xfer & ~order_ok;

  assign load  = sel & {NCH{xfer}};
  assign drain = valid_q & bus.ReadyOut;

  // A refill in the delivery cycle keeps the channel valid.
  assign valid_d = (valid_q & ~drain) | load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int n = 0; n < NCH; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int n = 0; n < NCH; n++) begin
        if (load[n]) begin
          data_q[n] <= bus.DataIn;
        end
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_err_q <= 1'b0;
    end else if (err_set) begin
      order_err_q <= 1'b1;
    end else if (bus.ErrClr) begin
      order_err_q <= 1'b0;
    end
  end

`ifdef DEMUX6_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.ErrClr) begin
      err_cnt_q <= err_set ? 8'd1 : 8'd0;
    end else if (err_set && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.ErrCnt = err_cnt_q;
`endif

  assign bus.ReadyIn  = ready_in;
  assign bus.ValidOut = valid_q;
  assign bus.OrderErr = order_err_q;
  assign bus.DataOut0 = data_q[0];
  assign bus.DataOut1 = data_q[1];
  assign bus.DataOut2 = data_q[2];
  assign bus.DataOut3 = data_q[3];
  assign bus.DataOut4 = data_q[4];
  assign bus.DataOut5 = data_q[5];

endmodule

// File: tb/tb_demux6out.sv
// Directed self-checking bench for demux6out: routing, back-pressure, streaming,
// invalid codes, async reset, and ErrCnt saturation when DEMUX6_ERRCNT_EN is set.
module tb_demux6out;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  demux6out_if #(.WIDTH(32), .NCH(6)) bus ();

  demux6out #(.WIDTH(32), .NCH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns so registered outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] order, input logic [31:0] data);
    bus.Order   = order;
    bus.DataIn  = data;
    bus.ValidIn = 1'b1;
  endtask

  task automatic idle();
    bus.ValidIn = 1'b0;
    bus.Order   = 3'd0;
    bus.DataIn  = '0;
  endtask

  function automatic logic [31:0] dout(input int n);
    case (n)
      0:       return bus.DataOut0;
      1:       return bus.DataOut1;
      2:       return bus.DataOut2;
      3:       return bus.DataOut3;
      4:       return bus.DataOut4;
      default: return bus.DataOut5;
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    bus.ReadyOut = 6'b0;
    bus.ErrClr   = 1'b0;

    // Reset state
    #1;
    check("rst_valid", 32'(bus.ValidOut), 32'h0);
    check("rst_err", 32'(bus.OrderErr), 32'h0);
    check("rst_d3", bus.DataOut3, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word to channel 3
    offer(3'd3, 32'hDEADBEEF);
    #1 check("t1_ready", 32'(bus.ReadyIn), 32'h1);
    step();
    idle();
    check("t1_valid", 32'(bus.ValidOut), 32'h08);
    check("t1_d3", bus.DataOut3, 32'hDEADBEEF);
    check("t1_d0", bus.DataOut0, 32'h0);
    check("t1_d5", bus.DataOut5, 32'h0);
    bus.ReadyOut = 6'b001000;
    step();
    bus.ReadyOut = 6'b0;
    check("t1_drained", 32'(bus.ValidOut), 32'h0);
    check("t1_hold", bus.DataOut3, 32'hDEADBEEF);

    // Back-pressure on a full channel 2
    offer(3'd2, 32'hA0A00002);
    step();
    offer(3'd2, 32'hBBBB0002);
    #1 check("t2_blocked", 32'(bus.ReadyIn), 32'h0);
    bus.ValidIn = 1'b0;
    #1 check("t2_ready_no_valid", 32'(bus.ReadyIn), 32'h0);
    bus.Order = 3'd1;
    #1 check("t2_other_ch", 32'(bus.ReadyIn), 32'h1);
    offer(3'd2, 32'hBBBB0002);
    step();
    check("t2_d2_kept", bus.DataOut2, 32'hA0A00002);
    check("t2_valid_kept", 32'(bus.ValidOut), 32'h04);
    bus.ReadyOut = 6'b000100;
    #1 check("t2_unblocked", 32'(bus.ReadyIn), 32'h1);
    step();
    idle();
    bus.ReadyOut = 6'b0;
    check("t2_refill_valid", 32'(bus.ValidOut), 32'h04);
    check("t2_refill_data", bus.DataOut2, 32'hBBBB0002);
    bus.ReadyOut = 6'h3F;
    step();
    check("t2_drained", 32'(bus.ValidOut), 32'h0);

    // Back-to-back words 1..6 to channels 0..5, all consumers ready
    for (int i = 0; i < 6; i++) begin
      offer(3'(i), 32'(i + 1));
      exp_q.push_back(32'(i + 1));
      #1 check($sformatf("t3_ready%0d", i), 32'(bus.ReadyIn), 32'h1);
      step();
      check($sformatf("t3_valid%0d", i), 32'(bus.ValidOut), 32'h1 << i);
      check($sformatf("t3_data%0d", i), dout(i), exp_q.pop_front());
    end
    idle();
    step();
    check("t3_empty", 32'(bus.ValidOut), 32'h0);
    check("t3_sb_empty", 32'(exp_q.size()), 32'h0);
    bus.ReadyOut = 6'b0;

    // Invalid orders: channel 1 full so ValidOut stability is visible
    offer(3'd1, 32'h00005555);
    step();
    offer(3'd7, 32'h00001234);
    #1 check("t4_ready7", 32'(bus.ReadyIn), 32'h1);
    step();
    check("t4_valid_same", 32'(bus.ValidOut), 32'h02);
    check("t4_err_set", 32'(bus.OrderErr), 32'h1);
    check("t4_d1_kept", bus.DataOut1, 32'h00005555);
`ifdef DEMUX6_ERRCNT_EN
    check("t4_cnt1", 32'(bus.ErrCnt), 32'h1);
`endif
    offer(3'd6, 32'h00006666);
    bus.ErrClr = 1'b1;
    step();
    check("t4_set_wins", 32'(bus.OrderErr), 32'h1);
`ifdef DEMUX6_ERRCNT_EN
    check("t4_cnt_clr_inc", 32'(bus.ErrCnt), 32'h1);
`endif
    idle();
    step();
    bus.ErrClr = 1'b0;
    check("t4_cleared", 32'(bus.OrderErr), 32'h0);

`ifdef DEMUX6_ERRCNT_EN
    // Saturation of the dropped-word counter
    check("t5_cnt_zero", 32'(bus.ErrCnt), 32'h0);
    offer(3'd7, 32'hFFFF0000);
    repeat (300) step();
    idle();
    check("t5_cnt_sat", 32'(bus.ErrCnt), 32'd255);
    bus.ErrClr = 1'b1;
    step();
    bus.ErrClr = 1'b0;
    check("t5_cnt_clr", 32'(bus.ErrCnt), 32'h0);
`endif

    // Fill channels 0 and 5, flag an error, then reset mid-cycle
    offer(3'd0, 32'h000000C0);
    step();
    offer(3'd5, 32'h000000C5);
    step();
    offer(3'd6, 32'h0);
    step();
    idle();
    check("t6_valid_pre", 32'(bus.ValidOut), 32'h23);
    check("t6_err_pre", 32'(bus.OrderErr), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t6_valid_async", 32'(bus.ValidOut), 32'h0);
    check("t6_d0_async", bus.DataOut0, 32'h0);
    check("t6_d5_async", bus.DataOut5, 32'h0);
    check("t6_err_async", 32'(bus.OrderErr), 32'h0);
    #1 rst = 1'b0;
    step();
    check("t6_valid_post", 32'(bus.ValidOut), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
